// File: rtl/olimp_acc_drain.sv
// Drain stage behind the vector MAC: realigns issue tags with the MAC latency, accumulates
// per-group lane sums and queues results in a 2-entry FWFT FIFO. Requant via OLIMP_ACC_DRAIN_REQUANT_EN.
module olimp_acc_drain #(
   parameter int MAC_LAT = 3,
   parameter int SHIFT_W = 5
) (
   input  logic               clk_dsp,
   input  logic               rst_n,
   input  logic               in_valid,
   input  logic               in_last,
   output logic               in_ready,
   input  logic [31:0]        acc0,
   input  logic [31:0]        acc1,
   input  logic [SHIFT_W-1:0] shift,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [31:0]        out_res0,
   output logic [31:0]        out_res1,
   output logic               out_ovf
);

   typedef struct packed {
      logic [31:0] res0;
      logic [31:0] res1;
      logic        ovf;
   } entry_t;

   logic [MAC_LAT-1:0] tag_v;
   logic [MAC_LAT-1:0] tag_l;
   logic [MAC_LAT-1:0] tag_v_nxt;
   logic [MAC_LAT-1:0] tag_l_nxt;
   logic               emerge_v;
   logic               emerge_last;

   logic [31:0]        sum0;
   logic [31:0]        sum1;
   logic [31:0]        add0;
   logic [31:0]        add1;
   logic               ovf0;
   logic               ovf1;
   logic               ovf_grp;

   logic [31:0]        fin0;
   logic [31:0]        fin1;
   logic               fin_ovf;

   entry_t             mem [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic [1:0]         count_nxt;
   logic               push;
   logic               pop;
   logic               ready_nxt;
   logic               ready_q;

   // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
   always_comb begin
      tag_v_nxt    = '0;
      tag_l_nxt    = '0;
      tag_v_nxt[0] = in_valid;
      tag_l_nxt[0] = in_valid & in_last;
      for (int i = 1; i < MAC_LAT; i++) begin
         tag_v_nxt[i] = tag_v[i-1];
         tag_l_nxt[i] = tag_l[i-1];
      end
   end

   assign emerge_v    = tag_v[MAC_LAT-1];
   assign emerge_last = emerge_v & tag_l[MAC_LAT-1];

   // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk_dsp or negedge rst_n) begin
      if (!rst_n) begin
         tag_v <= '0;
         tag_l <= '0;
      end else begin
         tag_v <= tag_v_nxt;
         tag_l <= tag_l_nxt;
      end
   end

   // Lane adders with signed-overflow detect; the emerging tag qualifies acc0/acc1 this cycle.
   always_comb begin
      add0 = sum0 + acc0;
      add1 = sum1 + acc1;
      ovf0 = (sum0[31] == acc0[31]) & (add0[31] != sum0[31]);
      ovf1 = (sum1[31] == acc1[31]) & (add1[31] != sum1[31]);
   end

   always_ff @(posedge clk_dsp or negedge rst_n) begin
      if (!rst_n) begin
         sum0    <= '0;
         sum1    <= '0;
         ovf_grp <= 1'b0;
      end else if (emerge_v) begin
         if (emerge_last) begin
            sum0    <= '0;
            sum1    <= '0;
            ovf_grp <= 1'b0;
         end else begin
            sum0    <= add0;
            sum1    <= add1;
            ovf_grp <= ovf_grp | ovf0 | ovf1;
         end
      end
   end

`ifdef OLIMP_ACC_DRAIN_REQUANT_EN
   // Returns {saturated, result}: round-half-up right shift, then clamp to int8.
   function automatic logic [32:0] requant(input logic [31:0] v, input logic [SHIFT_W-1:0] sh);
      logic signed [32:0] ext;
      logic signed [32:0] rnd;
      logic signed [32:0] r;
      logic [32:0]        res;
      ext = {v[31], v};
      rnd = (sh != '0) ? (33'sd1 <<< (sh - SHIFT_W'(1))) : 33'sd0;
      r   = (ext + rnd) >>> sh;
      if (r > 33'sd127) begin
         res = {1'b1, 32'd127};
      end else if (r < -33'sd128) begin
         res = {1'b1, 32'hFFFF_FF80};
      end else begin
         res = {1'b0, {24{r[7]}}, r[7:0]};
      end
      return res;
   endfunction

   logic [32:0] rq0;
   logic [32:0] rq1;

   always_comb begin
      rq0     = requant(add0, shift);
      rq1     = requant(add1, shift);
      fin0    = rq0[31:0];
      fin1    = rq1[31:0];
      fin_ovf = ovf_grp | ovf0 | ovf1 | rq0[32] | rq1[32];
   end
`else
   logic unused_shift;
   assign unused_shift = ^shift;

   always_comb begin
      fin0    = add0;
      fin1    = add1;
      fin_ovf = ovf_grp | ovf0 | ovf1;
   end
`endif

   // The full guard only matters after an issuer protocol violation; in_ready keeps it unreachable.
   assign pop  = (count != 2'd0) & out_ready;
   assign push = emerge_last & ((count != 2'd2) | pop);

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 2'd1;
         2'b01:   count_nxt = count - 2'd1;
         default: count_nxt = count;
      endcase
   end

   // Ready looks ahead: FIFO occupancy plus last-tags still in the MAC, both after this edge.
   assign ready_nxt = ($countones(tag_l_nxt) + int'(count_nxt)) < 2;

   // NOTE: the two FIFO entries are reset so out_res0/out_res1 read zero out of reset.
   always_ff @(posedge clk_dsp or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            mem[i] <= '0;
         end
         wr_ptr  <= 1'b0;
         rd_ptr  <= 1'b0;
         count   <= 2'd0;
         ready_q <= 1'b1;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {fin0, fin1, fin_ovf};
            wr_ptr      <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count   <= count_nxt;
         ready_q <= ready_nxt;
      end
   end

   assign in_ready  = ready_q;
   assign out_valid = (count != 2'd0);
   assign out_res0  = mem[rd_ptr].res0;
   assign out_res1  = mem[rd_ptr].res1;
   assign out_ovf   = mem[rd_ptr].ovf;

endmodule

// File: tb/tb_olimp_acc_drain.sv
// Self-checking bench for olimp_acc_drain: behavioural MAC delay line, group-level reference
// model and FIFO scoreboard; honours OLIMP_ACC_DRAIN_REQUANT_EN when defined.
module tb_olimp_acc_drain;

   localparam int MAC_LAT = 3;
   localparam int SHIFT_W = 5;

   typedef struct {
      logic [31:0] r0;
      logic [31:0] r1;
      logic        ovf;
   } res_t;

   logic               clk_dsp = 1'b0;
   logic               rst_n;
   logic               in_valid;
   logic               in_last;
   logic               in_ready;
   logic [31:0]        acc0;
   logic [31:0]        acc1;
   logic [SHIFT_W-1:0] shift;
   logic               out_valid;
   logic               out_ready;
   logic [31:0]        out_res0;
   logic [31:0]        out_res1;
   logic               out_ovf;

   logic [31:0] beat0;
   logic [31:0] beat1;
   logic [31:0] mac0 [MAC_LAT];
   logic [31:0] mac1 [MAC_LAT];

   res_t        exp_q[$];
   logic [31:0] m_sum0;
   logic [31:0] m_sum1;
   logic        m_ovf;
   int          n_checks = 0;
   int          n_pass = 0;
   bit          in_reset = 1'b1;
   bit          rand_out_ready = 1'b0;

   always #5 clk_dsp = ~clk_dsp;

   olimp_acc_drain #(.MAC_LAT(MAC_LAT), .SHIFT_W(SHIFT_W)) dut (
      .clk_dsp   (clk_dsp),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_last   (in_last),
      .in_ready  (in_ready),
      .acc0      (acc0),
      .acc1      (acc1),
      .shift     (shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res0  (out_res0),
      .out_res1  (out_res1),
      .out_ovf   (out_ovf)
   );

   // Stand-in MAC: fixed latency, never stalls, ignores reset.
   always @(posedge clk_dsp) begin
      mac0[0] <= beat0;
      mac1[0] <= beat1;
      for (int i = 1; i < MAC_LAT; i++) begin
         mac0[i] <= mac0[i-1];
         mac1[i] <= mac1[i-1];
      end
   end
   assign acc0 = mac0[MAC_LAT-1];
   assign acc1 = mac1[MAC_LAT-1];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic void lane_add(inout logic [31:0] s, input logic [31:0] a, inout logic ovf);
      longint full;
      full = longint'($signed(s)) + longint'($signed(a));
      if (full > 64'sd2147483647 || full < -64'sd2147483648) ovf = 1'b1;
      s = full[31:0];
   endfunction

   function automatic void finalize(input logic [31:0] s, output logic [31:0] r, output logic sat);
`ifdef OLIMP_ACC_DRAIN_REQUANT_EN
      longint v;
      int     sh;
      v   = longint'($signed(s));
      sh  = int'(shift);
      sat = 1'b0;
      if (sh > 0) v = v + (longint'(1) << (sh - 1));
      v = v >>> sh;
      if (v > 127) begin
         v   = 127;
         sat = 1'b1;
      end else if (v < -128) begin
         v   = -128;
         sat = 1'b1;
      end
      r = v[31:0];
`else
      r   = s;
      sat = 1'b0;
`endif
   endfunction

   // Scoreboard: every accepted head must match the oldest expected group.
   always @(negedge clk_dsp) begin
      res_t e;
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_out", out_valid, 1'b0);
         end else begin
            e = exp_q.pop_front();
            check("out_res0", out_res0, e.r0);
            check("out_res1", out_res1, e.r1);
            check("out_ovf", out_ovf, e.ovf);
         end
      end
   end

   // Groups issued but not yet popped equal fifo_count + lasts_in_flight.
   task automatic step();
      @(posedge clk_dsp);
      #1;
      if (!in_reset) check("in_ready", in_ready, exp_q.size() < 2);
      if (rand_out_ready) out_ready = ($urandom_range(0, 9) < 6);
   endtask

   task automatic wait_ready();
      int budget = 200;
      while (!in_ready && budget > 0) begin
         step();
         budget--;
      end
      if (!in_ready) check("ready_timeout", in_ready, 1'b1);
   endtask

   task automatic beat(input logic [31:0] a0, input logic [31:0] a1, input logic last);
      res_t e;
      logic s0;
      logic s1;
      wait_ready();
      in_valid = 1'b1;
      in_last  = last;
      beat0    = a0;
      beat1    = a1;
      lane_add(m_sum0, a0, m_ovf);
      lane_add(m_sum1, a1, m_ovf);
      if (last) begin
         finalize(m_sum0, e.r0, s0);
         finalize(m_sum1, e.r1, s1);
         e.ovf = m_ovf | s0 | s1;
         exp_q.push_back(e);
         m_sum0 = '0;
         m_sum1 = '0;
         m_ovf  = 1'b0;
      end
      step();
      in_valid = 1'b0;
      in_last  = 1'b0;
      beat0    = $urandom;
      beat1    = $urandom;
   endtask

   task automatic drain();
      int budget = 100;
      out_ready = 1'b1;
      while (exp_q.size() > 0 && budget > 0) begin
         step();
         budget--;
      end
      check("drain_empty", exp_q.size(), 0);
      step();
      check("drain_out_valid", out_valid, 1'b0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'($urandom_range(0, 200)) - 32'd100;
         2:       return 32'h7FFF_0000 + 32'($urandom_range(0, 65535));
         default: return 32'h8000_0000 + 32'($urandom_range(0, 65535));
      endcase
   endfunction

   initial begin
      int lat;
      int len;
      for (int i = 0; i < MAC_LAT; i++) begin
         mac0[i] = '0;
         mac1[i] = '0;
      end
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_last   = 1'b0;
      beat0     = '0;
      beat1     = '0;
      shift     = '0;
      out_ready = 1'b0;
      m_sum0    = '0;
      m_sum1    = '0;
      m_ovf     = 1'b0;

      repeat (3) @(posedge clk_dsp);
      #1;
      check("rst_in_ready", in_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_out_res0", out_res0, 32'd0);
      check("rst_out_res1", out_res1, 32'd0);
      check("rst_out_ovf", out_ovf, 1'b0);
      rst_n    = 1'b1;
      in_reset = 1'b0;
      step();

      // Single beat: latency is MAC_LAT+1 cycles from issue.
      out_ready = 1'b1;
      beat(32'd8, 32'd8, 1'b1);
      lat = 1;
      while (!out_valid && lat < 20) begin
         step();
         lat++;
      end
      check("latency", lat, MAC_LAT + 1);
      check("single_res0", out_res0, 32'd8);
      drain();

      // Four-beat group, then a fresh group.
      beat(32'd10, -32'sd50, 1'b0);
      beat(-32'sd3, -32'sd50, 1'b0);
      beat(32'd100, -32'sd50, 1'b0);
      beat(-32'sd7, -32'sd50, 1'b1);
      beat(32'd5, 32'd6, 1'b1);
      drain();

      // Backpressure: two groups fill the FIFO, the third waits.
      out_ready = 1'b0;
      beat(32'd1, 32'd2, 1'b1);
      beat(32'd3, 32'd4, 1'b1);
      check("bp_ready_low", in_ready, 1'b0);
      repeat (8) step();
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_hold_res0", out_res0, exp_q[0].r0);
      check("bp_hold_res1", out_res1, exp_q[0].r1);
      check("bp_still_low", in_ready, 1'b0);
      out_ready = 1'b1;
      beat(32'd5, 32'd6, 1'b1);
      drain();

      // Signed overflow wraps and is reported only for its own group.
      beat(32'h7FFF_FFF0, 32'd1, 1'b0);
      beat(32'h0000_0020, 32'd1, 1'b1);
      beat(32'd3, 32'd4, 1'b1);
      drain();

      // Requant cases (raw sums in the default build).
      shift = 5'd2;
      beat(32'd300, -32'sd6, 1'b1);
      drain();
      shift = 5'd0;
      beat(32'd1000, -32'sd1000, 1'b1);
      drain();
      shift = 5'd4;
      beat(32'd23, -32'sd24, 1'b1);
      drain();

      // Reset between beats 2 and 3 discards the partial group.
      beat(32'd11, 32'd22, 1'b0);
      beat(32'd33, 32'd44, 1'b0);
      in_reset = 1'b1;
      rst_n    = 1'b0;
      exp_q.delete();
      m_sum0 = '0;
      m_sum1 = '0;
      m_ovf  = 1'b0;
      @(posedge clk_dsp);
      #1;
      check("mid_rst_out_valid", out_valid, 1'b0);
      rst_n    = 1'b1;
      in_reset = 1'b0;
      check("mid_rst_in_ready", in_ready, 1'b1);
      beat(32'd55, 32'd66, 1'b1);
      drain();

      // Randomised groups with random consumer stalls.
      shift = 5'($urandom_range(0, 8));
      rand_out_ready = 1'b1;
      for (int g = 0; g < 60; g++) begin
         len = $urandom_range(1, 5);
         for (int b = 0; b < len; b++) begin
            beat(pick(), pick(), b == len - 1);
            if ($urandom_range(0, 3) == 0) step();
         end
      end
      rand_out_ready = 1'b0;
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
